// File: rtl/ones_comp_pkg.sv
// Shared types for the one's-complement result buffer: default result width
// and the converted sign-magnitude payload stored in the FIFO.
package ones_comp_pkg;

  localparam int unsigned OC_WIDTH = 4;
  localparam int unsigned OC_MAG_W = OC_WIDTH - 1;

  typedef struct packed {
    logic                sign;
    logic [OC_MAG_W-1:0] mag;
    logic                negzero;
  } oc_result_t;

endpackage

// File: rtl/ones_comp_to_signmag.sv
// Combinational one's-complement to sign-magnitude converter.
// Optional macro ONES_COMP_NEGZERO_NORM_EN stores negative zero as +0.
module ones_comp_to_signmag
  import ones_comp_pkg::*;
#(
  parameter int unsigned WIDTH = OC_WIDTH
) (
  input  logic [WIDTH-1:0] in_data,
  output oc_result_t       result
);

  always_comb begin
    result         = '0;
    result.negzero = &in_data;
    result.sign    = in_data[WIDTH-1];
    // Negative values carry their magnitude inverted in the low bits.
    result.mag     = OC_MAG_W'(in_data[WIDTH-1] ? ~in_data[WIDTH-2:0] : in_data[WIDTH-2:0]);
`ifdef ONES_COMP_NEGZERO_NORM_EN
    if (result.negzero) begin
      result.sign = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/ones_comp_result_buffer.sv
// Valid/ready FIFO of converted one's-complement results with a saturating
// negative-zero counter. Conversion option: ONES_COMP_NEGZERO_NORM_EN.
module ones_comp_result_buffer
  import ones_comp_pkg::*;
#(
  parameter int unsigned WIDTH = OC_WIDTH,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-2:0] out_mag,
  output logic             out_negzero,
  output logic [CNT_W-1:0] negzero_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  oc_result_t       conv;
  oc_result_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             push;
  logic             pop;

  ones_comp_to_signmag #(.WIDTH(WIDTH)) u_conv (
    .in_data (in_data),
    .result  (conv)
  );

  // Handshake flags come from stored occupancy only; no full-bypass path.
  assign in_ready  = (occ != OCC_W'(DEPTH));
  assign out_valid = (occ != OCC_W'(0));
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_sign    = mem[rd_ptr].sign;
  assign out_mag     = mem[rd_ptr].mag;
  assign out_negzero = mem[rd_ptr].negzero;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      negzero_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= conv;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      // Counter holds at all-ones rather than wrapping.
      if (push && conv.negzero && (negzero_cnt != '1)) begin
        negzero_cnt <= negzero_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ones_comp_result_buffer.sv
// Directed plus random bench for ones_comp_result_buffer, checked against a
// queue-based model of the buffered one's-complement values.
module tb_ones_comp_result_buffer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [WIDTH-2:0] out_mag;
  logic             out_negzero;
  logic [CNT_W-1:0] negzero_cnt;

  int checks   = 0;
  int failures = 0;

  int q[$];
  int mcnt;
  logic             prev_blocked;
  logic [WIDTH-1:0] prev_data;

  ones_comp_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_mag     (out_mag),
    .out_negzero (out_negzero),
    .negzero_cnt (negzero_cnt)
  );

  always #5 clk = ~clk;

  // Value interpretation of a 4-bit one's-complement word.
  function automatic int ref_sign(input int raw);
`ifdef ONES_COMP_NEGZERO_NORM_EN
    return (raw >= 8 && raw != 15) ? 1 : 0;
`else
    return (raw >= 8) ? 1 : 0;
`endif
  endfunction

  function automatic int ref_mag(input int raw);
    return (raw < 8) ? raw : (15 - raw);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'(q.size() > 0));
    check({tag, "_ready"}, 32'(in_ready), 32'(q.size() < int'(DEPTH)));
    check({tag, "_cnt"}, 32'(negzero_cnt), 32'(mcnt));
    if (q.size() > 0) begin
      check({tag, "_sign"}, 32'(out_sign), 32'(ref_sign(q[0])));
      check({tag, "_mag"}, 32'(out_mag), 32'(ref_mag(q[0])));
      check({tag, "_nz"}, 32'(out_negzero), 32'(q[0] == 15));
    end
  endtask

  task automatic cycle(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                       input string tag);
    bit do_push;
    bit do_pop;
    assert (!(prev_blocked && iv) || d == prev_data)
      else $error("upstream rule broken: data changed while stalled (%s)", tag);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    do_push   = iv && (q.size() < int'(DEPTH));
    do_pop    = (q.size() > 0) && ordy;
    prev_blocked = iv && !do_push;
    prev_data    = d;
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      q.push_back(int'(d));
      if (d == 4'hF && mcnt < CNT_MAX) mcnt++;
    end
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic do_reset(input int n, input string tag);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (n) @(posedge clk);
    q.delete();
    mcnt = 0;
    prev_blocked = 1'b0;
    @(negedge clk);
    check_state(tag);
    check({tag, "_sign0"}, 32'(out_sign), 32'd0);
    check({tag, "_mag0"}, 32'(out_mag), 32'd0);
    check({tag, "_nz0"}, 32'(out_negzero), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic             iv;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    prev_blocked = 1'b0; prev_data = '0; mcnt = 0;
    @(negedge clk);

    // Reset state
    do_reset(2, "t1_reset");

    // Single positive word, then pop
    cycle(1'b1, 4'b0101, 1'b1, "t2_push");
    check("t2_mag_const", 32'(out_mag), 32'h5);
    cycle(1'b0, 4'b0000, 1'b1, "t2_pop");
    check("t2_empty_const", 32'(out_valid), 32'd0);

    // Negative value and negative zero
    cycle(1'b1, 4'b1010, 1'b1, "t3_neg");
    check("t3_neg_mag_const", 32'(out_mag), 32'h5);
    cycle(1'b1, 4'b1111, 1'b1, "t3_nz");
    check("t3_nz_cnt_const", 32'(negzero_cnt), 32'd1);
    check("t3_nz_mag_const", 32'(out_mag), 32'd0);
    cycle(1'b0, 4'b0000, 1'b1, "t3_drain");

    // Stall downstream: third word held, ordered release, full + pop
    cycle(1'b1, 4'b0001, 1'b0, "t4_p1");
    cycle(1'b1, 4'b0010, 1'b0, "t4_p2");
    cycle(1'b1, 4'b0011, 1'b0, "t4_held");
    check("t4_full_ready_const", 32'(in_ready), 32'd0);
    check("t4_head_const", 32'(out_mag), 32'h1);
    cycle(1'b1, 4'b0011, 1'b1, "t5_pop_only");
    check("t5_head_const", 32'(out_mag), 32'h2);
    check("t5_ready_const", 32'(in_ready), 32'd1);
    cycle(1'b1, 4'b0011, 1'b1, "t5_push");
    check("t5_head3_const", 32'(out_mag), 32'h3);
    cycle(1'b0, 4'b0000, 1'b1, "t4_drain");
    check("t4_drained_const", 32'(out_valid), 32'd0);

    // Counter saturation and mid-stream reset
    do_reset(1, "t6_reset");
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 4'b1111, 1'b1, "t6_sat");
    end
    check("t6_sat_const", 32'(negzero_cnt), 32'd3);
    cycle(1'b1, 4'b0110, 1'b0, "t6_f1");
    cycle(1'b1, 4'b1001, 1'b0, "t6_f2");
    do_reset(1, "t6_midreset");
    check("t6_cnt_clear_const", 32'(negzero_cnt), 32'd0);

    // Random traffic
    d = 4'(($urandom) & 32'hF);
    for (int i = 0; i < 400; i++) begin
      iv = 1'($urandom_range(0, 1));
      if (!prev_blocked) d = 4'(($urandom) & 32'hF);
      if (prev_blocked) iv = 1'b1;
      cycle(iv, d, 1'($urandom_range(0, 1)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
